// File: rtl/datapath_sequencer.sv
// Microprogrammed control unit: replays a small loadable micro-program into the
// datapath, one micro-op per cycle, with jumps, zero-flag branch and a loop counter.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start          launch program at pc=0 (accepted in IDLE only)
//   zero           datapath status flag used by BRZ
//   prog_we        program write strobe (honoured in IDLE only)
//   prog_addr      program write address
//   prog_data      {op[2:0], k[K_W-1:0], cw[CW_W-1:0]}
//   ControlWord    registered control word to datapath
//   ConstantIn     registered constant to datapath
//   busy           high while the program runs
//   done           one-cycle pulse when the program ends
//   err            sticky illegal-opcode flag, cleared by the next accepted start
//
// Optional build macro DATAPATH_SEQ_STEP_EN adds input `step`: in RUN the
// sequencer only advances on edges where step=1.

module datapath_sequencer #(
   parameter int ADDR_W = 4,
   parameter int CW_W   = 13,
   parameter int K_W    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    zero,
`ifdef DATAPATH_SEQ_STEP_EN
   input  logic                    step,
`endif
   input  logic                    prog_we,
   input  logic [ADDR_W-1:0]       prog_addr,
   input  logic [3+K_W+CW_W-1:0]   prog_data,
   output logic [CW_W-1:0]         ControlWord,
   output logic [K_W-1:0]          ConstantIn,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int PW    = 3 + K_W + CW_W;
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] OP_EXEC   = 3'b000;
   localparam logic [2:0] OP_JMP    = 3'b001;
   localparam logic [2:0] OP_BRZ    = 3'b010;
   localparam logic [2:0] OP_SETCNT = 3'b011;
   localparam logic [2:0] OP_DJNZ   = 3'b100;
   localparam logic [2:0] OP_HALT   = 3'b101;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [K_W-1:0]    cnt, cnt_n;
   logic [CW_W-1:0]   cw_n;
   logic [K_W-1:0]    k_n;
   logic              busy_n, done_n, err_n;

   logic [PW-1:0]     mem [DEPTH];
   logic [PW-1:0]     instr;
   logic [2:0]        op;
   logic [K_W-1:0]    k_fld;
   logic [CW_W-1:0]   cw_fld;
   logic [ADDR_W-1:0] tgt;
   logic [ADDR_W-1:0] pc_inc;
   logic [K_W-1:0]    cnt_dec;
   logic              advance;

`ifdef DATAPATH_SEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   // Asynchronous read: the word at pc is decoded and committed on the same edge.
   assign instr   = mem[pc];
   assign op      = instr[PW-1 -: 3];
   assign k_fld   = instr[CW_W +: K_W];
   assign cw_fld  = instr[CW_W-1:0];
   assign tgt     = k_fld[ADDR_W-1:0];
   assign pc_inc  = pc + 1'b1;
   assign cnt_dec = cnt - 1'b1;

   // Program memory is deliberately not reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state == S_IDLE)) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         cnt         <= '0;
         ControlWord <= '0;
         ConstantIn  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         cnt         <= cnt_n;
         ControlWord <= cw_n;
         ConstantIn  <= k_n;
         busy        <= busy_n;
         done        <= done_n;
         err         <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      cnt_n   = cnt;
      cw_n    = '0;
      k_n     = '0;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = err;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_RUN;
               pc_n    = '0;
               err_n   = 1'b0;
               busy_n  = 1'b1;
            end
         end

         S_RUN: begin
            if (!advance) begin
               // Stalled: no register write in the datapath, constant held.
               k_n = ConstantIn;
            end else begin
               pc_n = pc_inc;
               unique case (op)
                  OP_EXEC: begin
                     cw_n = cw_fld;
                     k_n  = k_fld;
                  end
                  OP_JMP: begin
                     pc_n = tgt;
                  end
                  OP_BRZ: begin
                     if (zero) begin
                        pc_n = tgt;
                     end
                  end
                  OP_SETCNT: begin
                     cnt_n = k_fld;
                  end
                  OP_DJNZ: begin
                     // Loop back while the decremented count is non-zero;
                     // an already-zero counter simply falls through.
                     if (cnt != '0) begin
                        cnt_n = cnt_dec;
                        if (cnt_dec != '0) begin
                           pc_n = tgt;
                        end
                     end
                  end
                  OP_HALT: begin
                     state_n = S_IDLE;
                     pc_n    = '0;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end
                  default: begin
                     state_n = S_IDLE;
                     pc_n    = '0;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                     err_n   = 1'b1;
                  end
               endcase
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: table-driven program plus
// hand-written sequences, checked cycle by cycle against an expectation queue.

module tb_datapath_sequencer;

   localparam logic [2:0] OP_EXEC   = 3'b000;
   localparam logic [2:0] OP_JMP    = 3'b001;
   localparam logic [2:0] OP_BRZ    = 3'b010;
   localparam logic [2:0] OP_SETCNT = 3'b011;
   localparam logic [2:0] OP_DJNZ   = 3'b100;
   localparam logic [2:0] OP_HALT   = 3'b101;
   localparam logic [2:0] OP_ILL    = 3'b110;

   logic        clk;
   logic        reset;
   logic        start;
   logic        zero;
   logic        step;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [19:0] prog_data;
   logic [12:0] ControlWord;
   logic [3:0]  ConstantIn;
   logic        busy;
   logic        done;
   logic        err;

   datapath_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .zero       (zero),
`ifdef DATAPATH_SEQ_STEP_EN
      .step       (step),
`endif
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .ControlWord(ControlWord),
      .ConstantIn (ConstantIn),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // zero is the stimulus applied for the fetch; the rest is the expected output.
   typedef struct packed {
      logic        zero;
      logic [12:0] cw;
      logic [3:0]  k;
      logic        busy;
      logic        done;
      logic        err;
   } exp_t;

   typedef struct {
      logic [3:0]  addr;
      logic [2:0]  op;
      logic [3:0]  k;
      logic [12:0] cw;
      logic        zero;
      logic [12:0] ecw;
      logic [3:0]  ek;
      logic        edone;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[12];
   int   n_vec;
   int   n_miss;
   int   n5;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] outs();
      return {ControlWord, ConstantIn, busy, done, err};
   endfunction

   task automatic check(input string name, input logic [19:0] got,
                        input logic [19:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [2:0] op,
                     input logic [3:0] k, input logic [12:0] cw);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = {op, k, cw};
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic push(input logic z, input logic [12:0] cw,
                       input logic [3:0] k, input logic b,
                       input logic d, input logic e);
      exp_q.push_back({z, cw, k, b, d, e});
   endtask

   // Start the program, then pop one expectation per fetch edge.
   // With poke set, start/prog_we are hammered while the run is busy.
   task automatic run_queue(input string name, input bit poke);
      exp_t e;
      int   idx;
      idx   = 0;
      start = 1'b1;
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
      check({name, "/start"}, outs(), {13'h0, 4'h0, 1'b1, 1'b0, 1'b0});
      while (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         zero = e.zero;
         if (poke) begin
            start     = 1'b1;
            prog_we   = 1'b1;
            prog_addr = 4'd1;
            prog_data = {OP_EXEC, 4'hE, 13'h1ABC};
         end
         tick();
         if (ControlWord == 13'h0005) n5++;
         check($sformatf("%s/cyc%0d", name, idx), outs(),
               {e.cw, e.k, e.busy, e.done, e.err});
         idx++;
      end
      start   = 1'b0;
      prog_we = 1'b0;
      zero    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_done;
      n_vec     = 0;
      n_miss    = 0;
      n5        = 0;
      reset     = 1'b0;
      start     = 1'b0;
      zero      = 1'b0;
      step      = 1'b1;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;

      // Straight-line program touching every opcode; pc 9 is a trap skipped by BRZ.
      tbl[0]  = '{4'd0,  OP_EXEC,   4'd4, 13'h0003, 1'b0, 13'h0003, 4'd4, 1'b0};
      tbl[1]  = '{4'd1,  OP_EXEC,   4'd5, 13'h1003, 1'b0, 13'h1003, 4'd5, 1'b0};
      tbl[2]  = '{4'd2,  OP_SETCNT, 4'd1, 13'h1FFF, 1'b0, 13'h0000, 4'd0, 1'b0};
      tbl[3]  = '{4'd3,  OP_DJNZ,   4'd0, 13'h0000, 1'b0, 13'h0000, 4'd0, 1'b0};
      tbl[4]  = '{4'd4,  OP_DJNZ,   4'd0, 13'h0000, 1'b0, 13'h0000, 4'd0, 1'b0};
      tbl[5]  = '{4'd5,  OP_BRZ,    4'd0, 13'h0000, 1'b0, 13'h0000, 4'd0, 1'b0};
      tbl[6]  = '{4'd6,  OP_JMP,    4'd7, 13'h0000, 1'b0, 13'h0000, 4'd0, 1'b0};
      tbl[7]  = '{4'd7,  OP_EXEC,   4'hF, 13'h1FFF, 1'b0, 13'h1FFF, 4'hF, 1'b0};
      tbl[8]  = '{4'd8,  OP_BRZ,    4'd10, 13'h0000, 1'b1, 13'h0000, 4'd0, 1'b0};
      tbl[9]  = '{4'd10, OP_EXEC,   4'd9, 13'h0555, 1'b0, 13'h0555, 4'd9, 1'b0};
      tbl[10] = '{4'd11, OP_EXEC,   4'd2, 13'h0AA0, 1'b1, 13'h0AA0, 4'd2, 1'b0};
      tbl[11] = '{4'd12, OP_HALT,   4'd0, 13'h0000, 1'b0, 13'h0000, 4'd0, 1'b1};

      #3 reset = 1'b1;
      #1 check("reset_state", outs(), 20'h0);
      tick();
      @(negedge clk);
      reset = 1'b0;

      // Table-driven program.
      for (int i = 0; i < 12; i++) begin
         wr(tbl[i].addr, tbl[i].op, tbl[i].k, tbl[i].cw);
      end
      wr(4'd9, OP_EXEC, 4'd7, 13'h0777);
      for (int i = 0; i < 12; i++) begin
         push(tbl[i].zero, tbl[i].ecw, tbl[i].ek, !tbl[i].edone,
              tbl[i].edone, 1'b0);
      end
      run_queue("tbl", 1'b0);
      tick();
      check("tbl/done_drop", outs(), 20'h0);

      // Loop counter: body must execute exactly three times.
      wr(4'd0, OP_SETCNT, 4'd3, 13'h0000);
      wr(4'd1, OP_EXEC,   4'd1, 13'h0005);
      wr(4'd2, OP_DJNZ,   4'd1, 13'h0000);
      wr(4'd3, OP_HALT,   4'd0, 13'h0000);
      push(1'b0, 13'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 13'h0005, 4'd1, 1'b1, 1'b0, 1'b0);
         push(1'b0, 13'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
      end
      push(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
      n5 = 0;
      run_queue("djnz", 1'b0);
      check("djnz/count", 20'(n5), 20'd3);

      // Illegal opcode at pc 2: done pulse and sticky err.
      wr(4'd0, OP_EXEC, 4'd1, 13'h0001);
      wr(4'd1, OP_EXEC, 4'd2, 13'h0002);
      wr(4'd2, OP_ILL,  4'd0, 13'h0000);
      push(1'b0, 13'h0001, 4'd1, 1'b1, 1'b0, 1'b0);
      push(1'b0, 13'h0002, 4'd2, 1'b1, 1'b0, 1'b0);
      push(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
      run_queue("illeg", 1'b0);
      tick();
      check("illeg/idle", outs(), {13'h0, 4'h0, 1'b0, 1'b0, 1'b1});
      repeat (3) tick();
      check("illeg/sticky", outs(), {13'h0, 4'h0, 1'b0, 1'b0, 1'b1});

      // Write and start in the same cycle: the new HALT at pc 0 is fetched.
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = {OP_HALT, 4'd0, 13'h0000};
      push(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
      run_queue("errclr", 1'b0);

      // Writes/start ignored while busy; EXEC at pc 15 wraps to pc 0.
      wr(4'd0,  OP_BRZ,  4'd15, 13'h0000);
      wr(4'd1,  OP_HALT, 4'd0,  13'h0000);
      wr(4'd15, OP_EXEC, 4'd3,  13'h0123);
      for (int r = 0; r < 2; r++) begin
         push(1'b1, 13'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
         push(1'b0, 13'h0123, 4'd3, 1'b1, 1'b0, 1'b0);
         push(1'b0, 13'h0000, 4'd0, 1'b1, 1'b0, 1'b0);
         push(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
         run_queue(r == 0 ? "busy_poke" : "busy_reread", r == 0);
         tick();
         check($sformatf("wrap/idle%0d", r), outs(), 20'h0);
      end

      // Reset asserted while the third EXEC is on the outputs.
      for (int i = 0; i < 5; i++) begin
         wr(4'(i), OP_EXEC, 4'(i + 1), 13'(13'h0011 + i));
      end
      wr(4'd5, OP_HALT, 4'd0, 13'h0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("rst/third_exec", outs(), {13'h0013, 4'd3, 1'b1, 1'b0, 1'b0});
      #2 reset = 1'b1;
      #1 check("rst/async", outs(), 20'h0);
      tick();
      @(negedge clk);
      reset     = 1'b0;
      seen_done = 1'b0;
      repeat (6) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      check("rst/no_done", {19'h0, seen_done}, 20'h0);
      check("rst/idle", outs(), 20'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
